zbt_ssram_64_model: RTL and testbench

//  Synthesizable 64-bit flow-through ZBT SSRAM responder (2 x 32-bit chips) on FPGA block RAM.

---
 rtl/zbt_ssram_64_model.sv | 125 ++++++++++++
 tb/tb_zbt_ssram_64_model.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zbt_ssram_64_model.sv
// Flow-through 64-bit ZBT SSRAM stand-in (two 32-bit lanes) on block RAM.
// Read data is valid in the cycle after the address edge; writes commit one edge later; SnCKE=1 freezes the device.
module zbt_ssram_64_model #(
  parameter int SAW    = 20,
  parameter int MEM_AW = 12
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  input  logic [SAW-1:0] SADDR,
  input  logic [1:0]     SnCE,
  input  logic           SnWR,
  input  logic [7:0]     SnWBYTE,
  input  logic           SADVnLD,
  input  logic           SnCKE,
  input  logic           SnOE,
  input  logic           SDATAEN,
  input  logic [63:0]    SWDATA,
  output logic [63:0]    SRDATA,
  output logic           SERR,
  output logic [15:0]    RDCNT,
  output logic [15:0]    WRCNT
);
  typedef enum logic [1:0] {OP_IDLE = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2} op_t;
  localparam int DEPTH = 1 << MEM_AW;

  op_t               r_op;
  logic [SAW-1:0]    r_addr;
  logic [1:0]        r_ce;
  logic [7:0]        r_be;
  logic [63:0]       r_mem [DEPTH];
  logic [63:0]       r_rd_mem;
  logic [63:0]       r_fwd_dat;
  logic [7:0]        r_fwd_msk;
  logic              r_err;
  logic [15:0]       r_rdcnt;
  logic [15:0]       r_wrcnt;

  logic              w_en;
  logic              w_wr_commit;
  logic              w_fwd_hit;
  logic              w_proto_err;
  logic [7:0]        w_lane;
  logic [7:0]        w_wr_be;
  op_t               w_nxt_op;
  logic [SAW-1:0]    w_nxt_addr;
  logic [1:0]        w_nxt_ce;
  logic [MEM_AW-1:0] w_wr_idx;
  logic [MEM_AW-1:0] w_nxt_idx;
  logic [63:0]       w_rd_word;
  logic [63:0]       w_lane_mask;

  assign w_en        = ~SnCKE;
  assign w_lane      = {{4{r_ce[1]}}, {4{r_ce[0]}}};
  assign w_wr_be     = r_be & w_lane;
  assign w_wr_commit = w_en && (r_op == OP_WRITE);
  assign w_wr_idx    = r_addr[MEM_AW-1:0];
  assign w_nxt_idx   = w_nxt_addr[MEM_AW-1:0];
  // A read loading the location being written on this same edge must see the new bytes.
  assign w_fwd_hit   = w_wr_commit && (w_wr_idx == w_nxt_idx);

  assign w_proto_err = ((r_op == OP_WRITE) && SDATAEN) ||
                       (!SnOE && !SDATAEN) ||
                       (SADVnLD && (r_op == OP_IDLE));

  always_comb begin
    w_nxt_op   = r_op;
    w_nxt_addr = {r_addr[SAW-1:2], r_addr[1:0] + 2'd1};
    w_nxt_ce   = r_ce;
    if (!SADVnLD) begin
      w_nxt_addr = SADDR;
      w_nxt_ce   = ~SnCE;
      if (SnCE == 2'b11) w_nxt_op = OP_IDLE;
      else               w_nxt_op = SnWR ? OP_READ : OP_WRITE;
    end
  end

  // Array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge HCLK) begin
    if (w_wr_commit) begin
      for (int k = 0; k < 8; k++) begin
        if (w_wr_be[k]) r_mem[w_wr_idx][8*k +: 8] <= SWDATA[8*k +: 8];
      end
    end
    if (w_en && (w_nxt_op == OP_READ)) r_rd_mem <= r_mem[w_nxt_idx];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_op      <= OP_IDLE;
      r_addr    <= '0;
      r_ce      <= '0;
      r_be      <= '0;
      r_fwd_dat <= '0;
      r_fwd_msk <= '0;
      r_err     <= 1'b0;
      r_rdcnt   <= '0;
      r_wrcnt   <= '0;
    end else if (w_en) begin
      r_op   <= w_nxt_op;
      r_addr <= w_nxt_addr;
      r_ce   <= w_nxt_ce;
      r_be   <= ~SnWBYTE;
      if (w_nxt_op == OP_READ) begin
        r_fwd_msk <= w_fwd_hit ? w_wr_be : 8'h00;
        r_fwd_dat <= SWDATA;
      end
      if (w_proto_err) r_err <= 1'b1;
      if ((r_op == OP_READ) && (r_rdcnt != 16'hFFFF))  r_rdcnt <= r_rdcnt + 16'd1;
      if ((r_op == OP_WRITE) && (r_wrcnt != 16'hFFFF)) r_wrcnt <= r_wrcnt + 16'd1;
    end
  end

  always_comb begin
    w_lane_mask = {{32{r_ce[1]}}, {32{r_ce[0]}}};
    w_rd_word   = r_rd_mem;
    for (int k = 0; k < 8; k++) begin
      if (r_fwd_msk[k]) w_rd_word[8*k +: 8] = r_fwd_dat[8*k +: 8];
    end
  end

  assign SRDATA = ((r_op == OP_READ) && !SnOE) ? (w_rd_word & w_lane_mask) : 64'h0;
  assign SERR   = r_err;
  assign RDCNT  = r_rdcnt;
  assign WRCNT  = r_wrcnt;
endmodule

// File: tb/tb_zbt_ssram_64_model.sv
// Bench for zbt_ssram_64_model: directed scenarios plus random traffic against a transaction-level memory model.
module tb_zbt_ssram_64_model;
  localparam int SAW    = 20;
  localparam int MEM_AW = 12;

  logic           HCLK = 1'b0;
  logic           HRESETn = 1'b0;
  logic [SAW-1:0] saddr;
  logic [1:0]     snce;
  logic           snwr;
  logic [7:0]     snwbyte;
  logic           sadvnld;
  logic           sncke;
  logic           snoe;
  logic           sdataen;
  logic [63:0]    swdata;
  logic [63:0]    srdata;
  logic           serr;
  logic [15:0]    rdcnt;
  logic [15:0]    wrcnt;

  always #5 HCLK = ~HCLK;

  zbt_ssram_64_model #(.SAW(SAW), .MEM_AW(MEM_AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .SADDR(saddr), .SnCE(snce), .SnWR(snwr),
    .SnWBYTE(snwbyte), .SADVnLD(sadvnld), .SnCKE(sncke), .SnOE(snoe),
    .SDATAEN(sdataen), .SWDATA(swdata), .SRDATA(srdata), .SERR(serr),
    .RDCNT(rdcnt), .WRCNT(wrcnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Transaction-level reference: what the current data cycle is, and a sparse memory image.
  typedef enum {K_IDLE, K_READ, K_WRITE} kind_e;
  kind_e          m_kind;
  logic [SAW-1:0] m_addr;
  logic [1:0]     m_ce;
  logic [7:0]     m_be;
  logic [63:0]    m_snap;
  logic [63:0]    m_mem [int];
  int             m_rd;
  int             m_wr;
  bit             m_err;

  function automatic logic [63:0] rdmem(input int idx);
    return m_mem.exists(idx) ? m_mem[idx] : 64'h0;
  endfunction

  function automatic logic [63:0] exp_rd();
    return (m_kind == K_READ && !snoe) ? m_snap : 64'h0;
  endfunction

  function automatic logic [63:0] dpat(input int i);
    return 64'hC0DE_0000_0000_0040 + 64'(i);
  endfunction

  task automatic model_reset();
    m_kind = K_IDLE;
    m_addr = '0;
    m_ce   = '0;
    m_be   = '0;
    m_snap = '0;
    m_rd   = 0;
    m_wr   = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_edge();
    int          idx;
    logic [63:0] w;
    if (sncke) return;
    if (m_kind == K_WRITE) begin
      idx = int'(m_addr[MEM_AW-1:0]);
      w = rdmem(idx);
      for (int k = 0; k < 8; k++)
        if (m_be[k] && m_ce[k/4]) w[8*k +: 8] = swdata[8*k +: 8];
      m_mem[idx] = w;
      if (m_wr < 65535) m_wr++;
      if (sdataen) m_err = 1'b1;
    end else if (m_kind == K_READ) begin
      if (m_rd < 65535) m_rd++;
    end
    if (!snoe && !sdataen) m_err = 1'b1;
    if (!sadvnld) begin
      m_kind = (snce == 2'b11) ? K_IDLE : (snwr ? K_READ : K_WRITE);
      m_addr = saddr;
      m_ce   = ~snce;
    end else begin
      if (m_kind == K_IDLE) m_err = 1'b1;
      m_addr[1:0] = m_addr[1:0] + 2'd1;
    end
    m_be = ~snwbyte;
    if (m_kind == K_READ)
      m_snap = rdmem(int'(m_addr[MEM_AW-1:0])) & {{32{m_ce[1]}}, {32{m_ce[0]}}};
  endtask

  task automatic drv(input bit ld, input bit wr, input logic [SAW-1:0] a, input logic [1:0] ce,
                     input logic [7:0] wb, input bit oe, input bit den, input logic [63:0] wd,
                     input bit cke);
    sadvnld = ~ld;
    snwr    = wr;
    saddr   = a;
    snce    = ce;
    snwbyte = wb;
    snoe    = oe;
    sdataen = den;
    swdata  = wd;
    sncke   = cke;
  endtask

  task automatic half();
    #4;
    chk("srdata", srdata, exp_rd());
    chk("serr", 64'(serr), 64'(m_err));
    chk("rdcnt", 64'(rdcnt), 64'(m_rd));
    chk("wrcnt", 64'(wrcnt), 64'(m_wr));
  endtask

  task automatic edge_step();
    @(posedge HCLK);
    model_edge();
    #1;
  endtask

  task automatic tick();
    half();
    edge_step();
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    #2;
    model_reset();
    chk("rst_srdata", srdata, 64'h0);
    chk("rst_serr", 64'(serr), 64'h0);
    chk("rst_rdcnt", 64'(rdcnt), 64'h0);
    chk("rst_wrcnt", 64'(wrcnt), 64'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  initial begin
    drv(1'b1, 1'b1, '0, 2'b11, 8'hFF, 1'b1, 1'b1, 64'h0, 1'b0);
    do_reset();

    // Full write then read back
    drv(1'b1, 1'b0, 20'h10, 2'b00, 8'h00, 1'b1, 1'b1, 64'h0, 1'b0); tick();
    drv(1'b1, 1'b1, 20'h10, 2'b00, 8'hFF, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0); tick();
    drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b0); half();
    chk("t1_rd", srdata, 64'h0123_4567_89AB_CDEF); edge_step();
    drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b1, 1'b1, 64'h0, 1'b0); half();
    chk("t1_wrcnt", 64'(wrcnt), 64'd1);
    chk("t1_rdcnt", 64'(rdcnt), 64'd1); edge_step();

    // Low chip only, low bytes only
    drv(1'b1, 1'b0, 20'h20, 2'b00, 8'h00, 1'b1, 1'b1, 64'h0, 1'b0); tick();
    drv(1'b1, 1'b0, 20'h20, 2'b10, 8'hF0, 1'b1, 1'b0, 64'h0, 1'b0); tick();
    drv(1'b1, 1'b1, 20'h20, 2'b00, 8'hFF, 1'b1, 1'b0, 64'hFFFF_FFFF_1111_1111, 1'b0); tick();
    drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b0); half();
    chk("t2_partial", srdata, 64'h0000_0000_1111_1111); edge_step();

    // Write immediately followed by read of the same word
    drv(1'b1, 1'b0, 20'h30, 2'b00, 8'h00, 1'b1, 1'b1, 64'h0, 1'b0); tick();
    drv(1'b1, 1'b1, 20'h30, 2'b00, 8'hFF, 1'b1, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0); tick();
    drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b0); half();
    chk("t3_fwd", srdata, 64'hAAAA_AAAA_AAAA_AAAA); edge_step();

    // Burst wrap with a two-cycle clock-enable stall
    drv(1'b1, 1'b0, 20'h40, 2'b00, 8'h00, 1'b1, 1'b1, 64'h0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 1'b0, 20'h0, 2'b00, 8'h00, 1'b1, 1'b0, dpat(i), 1'b0); tick();
    end
    drv(1'b1, 1'b1, 20'h43, 2'b00, 8'hFF, 1'b1, 1'b0, dpat(3), 1'b0); tick();
    drv(1'b0, 1'b1, 20'h0, 2'b00, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b0); half();
    chk("t4_a43", srdata, dpat(3)); edge_step();
    drv(1'b0, 1'b1, 20'h0, 2'b00, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b1); half();
    chk("t4_stall0", srdata, dpat(0)); edge_step();
    drv(1'b0, 1'b1, 20'h0, 2'b00, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b1); half();
    chk("t4_stall1", srdata, dpat(0)); edge_step();
    drv(1'b0, 1'b1, 20'h0, 2'b00, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b0); half();
    chk("t4_a40", srdata, dpat(0)); edge_step();
    drv(1'b0, 1'b1, 20'h0, 2'b00, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b0); half();
    chk("t4_a41", srdata, dpat(1)); edge_step();
    drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b0); half();
    chk("t4_a42", srdata, dpat(2));
    chk("t4_serr", 64'(serr), 64'h0); edge_step();

    // Random traffic over a pre-written window, with aliased upper address bits
    for (int i = 0; i < 17; i++) begin
      drv(1'b1, 1'b0, {8'($urandom), 8'h10, 4'(i)}, (i < 16) ? 2'b00 : 2'b11, 8'h00,
          1'b1, (m_kind != K_WRITE), {$urandom, $urandom}, 1'b0);
      tick();
    end
    for (int i = 0; i < 1500; i++) begin
      bit cke;
      bit ld;
      bit oe;
      bit den;
      cke = ($urandom_range(0, 9) == 0);
      ld  = !(m_kind != K_IDLE && $urandom_range(0, 2) == 0);
      den = (m_kind != K_WRITE);
      oe  = (m_kind == K_WRITE) ? 1'b1 :
            (m_kind == K_READ) ? ($urandom_range(0, 4) == 0) : 1'($urandom);
      drv(ld, 1'($urandom), {8'($urandom), 8'h10, 4'($urandom)}, 2'($urandom_range(0, 3)),
          8'($urandom), oe, den, {$urandom, $urandom}, cke);
      tick();
    end
    drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b1, (m_kind != K_WRITE), 64'h0, 1'b0); tick();
    drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b1, 1'b1, 64'h0, 1'b0); half();
    chk("rand_serr", 64'(serr), 64'h0); edge_step();

    // Bus contention sets a sticky error
    drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b1, 1'b1, 64'h0, 1'b0); half();
      chk("t5_sticky", 64'(serr), 64'h1); edge_step();
    end
    do_reset();

    // Advance after deselect
    drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b1, 1'b1, 64'h0, 1'b0); tick();
    drv(1'b0, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b1, 1'b1, 64'h0, 1'b0); tick();
    drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b1, 1'b1, 64'h0, 1'b0); half();
    chk("t5_adv_idle", 64'(serr), 64'h1); edge_step();

    // Reset during a write data cycle drops the write but keeps memory
    drv(1'b1, 1'b0, 20'h10, 2'b00, 8'h00, 1'b1, 1'b1, 64'h0, 1'b0); tick();
    drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b1, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    do_reset();
    drv(1'b1, 1'b1, 20'h10, 2'b00, 8'hFF, 1'b1, 1'b1, 64'h0, 1'b0); tick();
    drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b0); half();
    chk("t5_mem_kept", srdata, 64'h0123_4567_89AB_CDEF); edge_step();

    // Write counter saturation
    drv(1'b1, 1'b0, 20'h200, 2'b00, 8'h00, 1'b1, 1'b1, 64'h0, 1'b0); tick();
    for (int i = 0; i < 66000; i++) begin
      drv(1'b0, 1'b0, 20'h0, 2'b00, 8'h00, 1'b1, 1'b0, {$urandom, $urandom}, 1'b0); tick();
    end
    drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b1, 1'b0, 64'h0, 1'b0); tick();
    drv(1'b1, 1'b1, 20'h0, 2'b11, 8'hFF, 1'b1, 1'b1, 64'h0, 1'b0); half();
    chk("t6_wrcnt_sat", 64'(wrcnt), 64'hFFFF);
    chk("t6_rdcnt", 64'(rdcnt), 64'd1); edge_step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
